// File: rtl/perceptron_update_ctrl.sv
// perceptron_update_ctrl: queues branch outcomes, zero-sweeps and trains the perceptron weight tables
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   upd_valid/upd_ready       execute-stage update handshake
//   upd_pc/dir/miss/sum/ghr   update payload (index taken from upd_pc[INDEX_BITS+1:2])
//   fetch_rd_active           fetch owns the shared table read port this cycle
//   fetch_stall_req           controller has been starved and asks fetch to yield
//   tbl_rd_sel/tbl_rd_addr    controller read request; tbl_rd_hob/lob registered read data
//   tbl_wr_*                  table write port (HOB, HOB complement, LOB)
//   init_done, busy           sweep finished; FSM active or updates pending
module perceptron_update_ctrl #(
   parameter int GHR_SIZE     = 12,
   parameter int INDEX_BITS   = 6,
   parameter int HOB          = 3,
   parameter int LOB          = 5,
   parameter int QDEPTH       = 4,
   parameter int THETA        = 37,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      upd_valid,
   output logic                      upd_ready,
   input  logic [31:0]               upd_pc,
   input  logic                      upd_dir,
   input  logic                      upd_miss,
   input  logic [6:0]                upd_sum,
   input  logic [GHR_SIZE-1:0]       upd_ghr,
   input  logic                      fetch_rd_active,
   output logic                      fetch_stall_req,
   output logic                      tbl_rd_sel,
   output logic [INDEX_BITS-1:0]     tbl_rd_addr,
   input  logic [HOB*GHR_SIZE-1:0]   tbl_rd_hob,
   input  logic [LOB*GHR_SIZE-1:0]   tbl_rd_lob,
   output logic                      tbl_wr_en,
   output logic [INDEX_BITS-1:0]     tbl_wr_addr,
   output logic [HOB*GHR_SIZE-1:0]   tbl_wr_hob,
   output logic [HOB*GHR_SIZE-1:0]   tbl_wr_hob_c,
   output logic [LOB*GHR_SIZE-1:0]   tbl_wr_lob,
   output logic                      init_done,
   output logic                      busy
);
   localparam int W  = HOB + LOB;
   localparam int PW = $clog2(QDEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = INDEX_BITS + 2 + 7 + GHR_SIZE;
   localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, RD = 3'd2, RDW = 3'd3, WR = 3'd4;
   localparam logic [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [7:0] THETA_V = 8'(THETA);
   localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);

   logic [2:0]              state_q, state_d;
   logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]           starve_q, starve_d;
   logic [PW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [HOB*GHR_SIZE-1:0] cap_hob_q, cap_hob_d, new_hob, new_hob_c;
   logic [LOB*GHR_SIZE-1:0] cap_lob_q, cap_lob_d, new_lob;
   logic [EW-1:0]           mem_q [QDEPTH];
   logic [EW-1:0]           head;
   logic [INDEX_BITS-1:0]   h_idx;
   logic                    h_dir, h_miss;
   logic [6:0]              h_sum;
   logic [GHR_SIZE-1:0]     h_ghr;
   logic [7:0]              sum_abs;
   logic                    empty, full, push, pop, train, unused_pc;

   assign unused_pc = ^{upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

   // pointers carry one extra wrap bit to tell full from empty
   assign empty = wr_ptr_q == rd_ptr_q;
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push  = upd_valid & upd_ready;
   assign head  = mem_q[rd_ptr_q[PW-1:0]];
   assign {h_idx, h_dir, h_miss, h_sum, h_ghr} = head;

   // eight bits so that |-64| = 64 is representable
   assign sum_abs = h_sum[6] ? 8'd0 - {1'b1, h_sum} : {1'b0, h_sum};
   assign train   = h_miss | (sum_abs <= THETA_V);

   assign init_done       = state_q != INIT;
   assign upd_ready       = init_done & ~full;
   assign busy            = reset_n & ((state_q != IDLE) | ~empty);
   assign tbl_rd_sel      = state_q == RD;
   assign tbl_rd_addr     = h_idx;
   assign fetch_stall_req = tbl_rd_sel & (starve_q >= S_LIM);

   // reset holds the FSM in INIT, so the write enable is gated to stay quiet until release
   assign tbl_wr_en    = reset_n & ((state_q == INIT) | (state_q == WR));
   assign tbl_wr_addr  = (state_q == INIT) ? cnt_q : h_idx;
   assign tbl_wr_hob   = (state_q == WR) ? new_hob : '0;
   assign tbl_wr_hob_c = (state_q == WR) ? new_hob_c : '0;
   assign tbl_wr_lob   = (state_q == WR) ? new_lob : '0;

   for (genvar i = 0; i < GHR_SIZE; i++) begin : g_w
      logic [W-1:0] w, wn, wc;
      assign w  = {cap_hob_q[i*HOB +: HOB], cap_lob_q[i*LOB +: LOB]};
      assign wn = (h_dir == h_ghr[i]) ? ((w == W_MAX) ? w : w + 1'b1)
                                      : ((w == W_MIN) ? w : w - 1'b1);
      // negating the most negative weight saturates to the most positive
      assign wc = (wn == W_MIN) ? W_MAX : -wn;
      assign new_hob[i*HOB +: HOB]   = wn[W-1:LOB];
      assign new_lob[i*LOB +: LOB]   = wn[LOB-1:0];
      assign new_hob_c[i*HOB +: HOB] = wc[W-1:LOB];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      starve_d  = starve_q;
      cap_hob_d = cap_hob_q;
      cap_lob_d = cap_lob_q;
      pop       = 1'b0;
      case (state_q)
         INIT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (&cnt_q) ? IDLE : INIT;
         end
         IDLE: begin
            pop     = ~empty & ~train;
            state_d = (~empty & train) ? RD : IDLE;
         end
         RD: begin
            state_d  = fetch_rd_active ? RD : RDW;
            starve_d = ~fetch_rd_active ? '0 : (starve_q < S_LIM) ? starve_q + 1'b1 : starve_q;
         end
         RDW: begin
            cap_hob_d = tbl_rd_hob;
            cap_lob_d = tbl_rd_lob;
            state_d   = WR;
         end
         WR: begin
            pop     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         starve_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cap_hob_q <= '0;
         cap_lob_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cap_hob_q <= cap_hob_d;
         cap_lob_q <= cap_lob_d;
      end

   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= {upd_pc[INDEX_BITS+1:2], upd_dir, upd_miss, upd_sum, upd_ghr};
endmodule

// File: tb/tb_perceptron_update_ctrl.sv
// tb_perceptron_update_ctrl: scoreboard bench for perceptron_update_ctrl with a behavioural weight-table RAM
module tb_perceptron_update_ctrl;
   logic        clk = 1'b0, reset_n = 1'b1;
   logic        upd_valid, upd_ready, upd_dir, upd_miss;
   logic [31:0] upd_pc;
   logic [6:0]  upd_sum;
   logic [11:0] upd_ghr;
   logic        fetch_rd_active, fetch_stall_req, tbl_rd_sel, tbl_wr_en, init_done, busy;
   logic [5:0]  tbl_rd_addr, tbl_wr_addr;
   logic [35:0] rd_hob, tbl_wr_hob, tbl_wr_hob_c;
   logic [59:0] rd_lob, tbl_wr_lob;

   perceptron_update_ctrl dut (
      .clk(clk), .reset_n(reset_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_dir(upd_dir), .upd_miss(upd_miss), .upd_sum(upd_sum), .upd_ghr(upd_ghr),
      .fetch_rd_active(fetch_rd_active), .fetch_stall_req(fetch_stall_req),
      .tbl_rd_sel(tbl_rd_sel), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_hob(rd_hob), .tbl_rd_lob(rd_lob),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_hob(tbl_wr_hob),
      .tbl_wr_hob_c(tbl_wr_hob_c), .tbl_wr_lob(tbl_wr_lob), .init_done(init_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  a;
      logic [35:0] h;
      logic [35:0] hc;
      logic [59:0] l;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          ref_w [64][12];
   int          n_cmp = 0, n_bad = 0, sel_cnt = 0;
   logic [35:0] mem_hob [64];
   logic [59:0] mem_lob [64];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_idx = '0;
   logic [35:0] poke_h = '0;
   logic [59:0] poke_l = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // weight table: 1R1W with registered read
   always @(posedge clk) begin
      if (tbl_wr_en) begin
         mem_hob[tbl_wr_addr] <= tbl_wr_hob;
         mem_lob[tbl_wr_addr] <= tbl_wr_lob;
      end else if (poke_en) begin
         mem_hob[poke_idx] <= poke_h;
         mem_lob[poke_idx] <= poke_l;
      end
      if (tbl_rd_sel) begin
         rd_hob <= mem_hob[tbl_rd_addr];
         rd_lob <= mem_lob[tbl_rd_addr];
      end
   end

   always @(negedge clk)
      if (reset_n) begin
         if (tbl_rd_sel) sel_cnt++;
         if (tbl_wr_en && init_done) begin
            if (exp_q.size() == 0) check("unexp_wr", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", tbl_wr_addr, mon_e.a);
               check("wr_hob", tbl_wr_hob, mon_e.h);
               check("wr_hob_c", tbl_wr_hob_c, mon_e.hc);
               check("wr_lob", tbl_wr_lob, mon_e.l);
            end
         end
      end

   task automatic send(input logic [31:0] pc, input logic dir, input logic miss,
                       input logic [6:0] sum, input logic [11:0] ghr);
      int n = 0;
      int s, v;
      exp_t e;
      logic [7:0] b, c;
      logic [5:0] idx;
      @(negedge clk);
      while (!upd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!upd_ready) check("ready_wait", 0, 1);
      upd_pc = pc; upd_dir = dir; upd_miss = miss; upd_sum = sum; upd_ghr = ghr; upd_valid = 1'b1;
      idx = pc[7:2];
      s = $signed(sum);
      if (miss || (s < 0 ? -s : s) <= 37) begin
         e.a = idx;
         for (int i = 0; i < 12; i++) begin
            v = ref_w[idx][i] + ((dir == ghr[i]) ? 1 : -1);
            v = v > 127 ? 127 : v < -128 ? -128 : v;
            ref_w[idx][i] = v;
            b = 8'(v);
            c = 8'(v == -128 ? 127 : -v);
            e.h[i*3 +: 3]  = b[7:5];
            e.l[i*5 +: 5]  = b[4:0];
            e.hc[i*3 +: 3] = c[7:5];
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic poke(input logic [5:0] idx, input logic [7:0] w);
      @(negedge clk);
      poke_idx = idx; poke_h = {12{w[7:5]}}; poke_l = {12{w[4:0]}}; poke_en = 1'b1;
      for (int i = 0; i < 12; i++) ref_w[idx][i] = $signed(w);
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic init_seq();
      for (int k = 0; k < 64; k++)
         for (int i = 0; i < 12; i++) ref_w[k][i] = 0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 64; k++) begin
         #1;
         check("init_en", tbl_wr_en, 1);
         check("init_addr", tbl_wr_addr, k);
         check("init_data", |{tbl_wr_hob, tbl_wr_hob_c, tbl_wr_lob}, 0);
         @(negedge clk);
      end
      #1;
      check("init_done", init_done, 1);
      check("init_ready", upd_ready, 1);
      check("init_wr_off", tbl_wr_en, 0);
   endtask

   task automatic wait_wr(output int n);
      n = 0;
      while (!tbl_wr_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tbl_wr_en) check("wr_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", busy || exp_q.size() != 0, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", upd_ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_wr_en", tbl_wr_en, 0);
      check("rst_rd_sel", tbl_rd_sel, 0);
      check("rst_stall", fetch_stall_req, 0);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      int n, sel0, k;
      logic [6:0]  sums [4];
      logic [35:0] old_h;
      logic [59:0] old_l;
      sums = '{7'd37, 7'd38, 7'd90, 7'd64};
      upd_valid = 1'b0; upd_dir = 1'b0; upd_miss = 1'b0; upd_pc = '0; upd_sum = '0; upd_ghr = '0;
      fetch_rd_active = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs();
      repeat (3) @(negedge clk);
      init_seq();
      // single +1 update onto a zeroed entry, with head-to-write latency
      send(32'h10, 1'b1, 1'b1, 7'd0, 12'hFFF);
      wait_wr(n);
      check("wr_latency", n, 3);
      drain();
      send(32'h14, 1'b1, 1'b0, 7'd0, 12'hA5C);
      drain();
      // confident correct prediction is dropped in one IDLE cycle
      sel0 = sel_cnt;
      send(32'h10, 1'b1, 1'b0, 7'd50, 12'hFFF);
      check("filt_busy0", busy, 1);
      @(negedge clk);
      check("filt_busy", busy, 0);
      check("filt_sel", sel_cnt - sel0, 0);
      send(32'h10, 1'b0, 1'b0, 7'd91, 12'h000);
      wait_wr(n);
      check("neg37_latency", n, 3);
      drain();
      for (int j = 0; j < 4; j++) send(32'h30, j[0], 1'b0, sums[j], 12'h3C3);
      drain();
      // saturation at both ends
      poke(6'd8, 8'h7F);
      send(32'h20, 1'b1, 1'b1, 7'd0, 12'hFFF);
      drain();
      poke(6'd9, 8'h80);
      send(32'h24, 1'b0, 1'b1, 7'd0, 12'hFFF);
      drain();
      // starvation of the read port
      fetch_rd_active = 1'b1;
      send(32'h18, 1'b1, 1'b1, 7'd0, 12'h0F0);
      n = 0;
      while (!tbl_rd_sel && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("starve_rd", tbl_rd_sel, 1);
      repeat (7) @(negedge clk);
      check("stall_rd8", fetch_stall_req, 0);
      @(negedge clk);
      check("stall_rd9", fetch_stall_req, 1);
      fetch_rd_active = 1'b0;
      #1 check("stall_grant", fetch_stall_req, 1);
      @(negedge clk);
      check("rdw_sel", tbl_rd_sel, 0);
      check("rdw_stall", fetch_stall_req, 0);
      @(negedge clk);
      check("rdw_then_wr", tbl_wr_en, 1);
      drain();
      // fill the queue while the head is blocked
      fetch_rd_active = 1'b1;
      for (int j = 0; j < 4; j++) send(32'h40 + 32'(j * 4), j[0], 1'b1, 7'd0, 12'h5A5 ^ 12'(j));
      check("full_ready", upd_ready, 0);
      fetch_rd_active = 1'b0;
      wait_wr(n);
      check("wr_ready", upd_ready, 0);
      @(negedge clk);
      check("pop_ready", upd_ready, 1);
      // reset in the middle of the next WR cycle
      k = 0;
      do begin
         @(posedge clk);
         #2;
         k++;
      end while (!tbl_wr_en && k < 10);
      check("wr2_seen", tbl_wr_en, 1);
      old_h = mem_hob[17];
      old_l = mem_lob[17];
      reset_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk);
      #1;
      check("abort_hob", mem_hob[17], old_h);
      check("abort_lob", mem_lob[17], old_l);
      exp_q.delete();
      init_seq();
      check("reinit_busy", busy, 0);
      send(32'h44, 1'b0, 1'b1, 7'd0, 12'h00F);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/perceptron_update_ctrl.md
# perceptron_update_ctrl

Sequences training of the perceptron branch predictor's weight tables (HOB, HOB-complement, LOB; 1R1W, registered read). It queues execute-stage branch outcomes and sweeps zero weights into every entry after reset. It performs the read-modify-write per trained update and arbitrates the shared table read port against fetch lookups. It sits between execute and the weight tables, beside the fetch-stage predictor.

## Interface
- GHR_SIZE, 12, history length = weights per entry
- INDEX_BITS, 6, table index width (index = PC[INDEX_BITS+1:2])
- HOB, 3, high-order weight bits; LOB, 5, low-order bits (HOB+LOB = 8)
- QDEPTH, 4, update queue depth (power of 2)
- THETA, 37, training threshold on |sum|
- STARVE_LIMIT, 8, denied read cycles before requesting a fetch stall

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- upd_valid / upd_ready  in / out  1 / 1  update handshake
- upd_pc  in  32  branch PC
- upd_dir  in  1  resolved direction (1 = taken)
- upd_miss  in  1  prediction was wrong
- upd_sum  in  7  signed perceptron sum at prediction time
- upd_ghr  in  GHR_SIZE  history snapshot used for the prediction
- fetch_rd_active  in  1  fetch needs the table read port this cycle
- fetch_stall_req  out  1  asks fetch to release the read port
- tbl_rd_sel  out  1  1 = controller drives table read address
- tbl_rd_addr  out  INDEX_BITS  controller read index
- tbl_rd_hob / tbl_rd_lob  in  HOB*GHR_SIZE / LOB*GHR_SIZE  table read data
- tbl_wr_en  out  1; tbl_wr_addr  out  INDEX_BITS
- tbl_wr_hob / tbl_wr_hob_c  out  HOB*GHR_SIZE; tbl_wr_lob  out  LOB*GHR_SIZE
- init_done  out  1  sweep finished
- busy  out  1  state != IDLE or queue non-empty

## Operation
- Queue: FIFO of {index, dir, miss, sum, ghr}.
  - upd_ready = init_done & !full. Push on upd_valid & upd_ready.
  - Push and pop in the same cycle are legal.
- States:
  - INIT: write entry k = 0..2^INDEX_BITS-1, one per cycle, all data fields zero; last write -> IDLE, init_done=1.
  - IDLE: if queue non-empty, examine head.
    - Train = miss | (|sum| <= THETA), with |-64| = 64.
    - Not train: pop, stay IDLE; no read, no write.
    - Train: -> RD.
  - RD: tbl_rd_sel=1, tbl_rd_addr=head index.
    - Granted when fetch_rd_active=0 -> RDW.
    - Otherwise stay in RD and increment the starve counter.
  - RDW: capture tbl_rd_hob/lob -> WR.
  - WR: tbl_wr_en=1, write computed entry to head index, pop -> IDLE.
- Starvation:
  - fetch_stall_req=1 while in RD with starve count >= STARVE_LIMIT.
  - The counter clears on grant.
- Arithmetic, per weight i:
  - w = signed {hob_i, lob_i} (8 bits).
  - w' = w+1 if dir == ghr[i], else w-1, saturated to [-128, 127].
  - tbl_wr_hob_i / tbl_wr_lob_i = w'[7:5] / w'[4:0].
  - tbl_wr_hob_c_i = top HOB bits of sat(-w'), so -(-128) = 127.
- Sequential RMW means back-to-back updates to the same index see the prior write; no forwarding is needed.

## Timing
- Reset (async assert):
  - All outputs 0: upd_ready, init_done, tbl_wr_en, tbl_rd_sel, fetch_stall_req, busy=0.
  - Queue is emptied and state -> INIT.
  - Release: first INIT write in the first clk after reset_n rises. An in-flight RMW is abandoned (no partial write).
- INIT: 2^INDEX_BITS consecutive write cycles. init_done and upd_ready rise the cycle after the last write.
- Trained update:
  - Minimum 3 cycles, head to write: RD, RDW, WR.
  - Next head is examined the cycle after WR.
- Non-trained update: 1 cycle in IDLE.
- Read port: RAM samples tbl_rd_addr at the edge ending a granted RD cycle; data is valid during RDW.
- fetch_stall_req:
  - Asserts in the cycle where starve count reaches STARVE_LIMIT.
  - Deasserts the cycle after grant.

## Test plan
- Reset release, INIT=6 -> tbl_wr_en high cycles 1..64, addr 0..63, data 0; init_done=1 and upd_ready=1 at cycle 65.
- Zeroed table; push pc=0x10, dir=1, miss=1, ghr=0xFFF -> one write to addr 4:
  - every weight +1 (hob=000, lob=00001, hob_c=111);
  - write lands 3 cycles after the push is at head.
- Saturation:
  - entry weights all 127, dir=1, ghr=0xFFF -> weights stay 127, hob_c=100;
  - entry weights all -128, dir=0, ghr=0xFFF -> weights stay -128, hob_c=011.
- Filter: miss=0, sum=50 -> popped in 1 cycle, no tbl_rd_sel, no tbl_wr_en.
  - With sum=-37 instead -> trained.
- Starvation: hold fetch_rd_active=1 with a trained update pending -> fetch_stall_req=1 after 8 RD cycles.
  - Drop fetch_rd_active -> RDW next cycle, stall_req low the cycle after grant.
- Fill the queue with 4 trained updates -> upd_ready=0; pop -> upd_ready=1 next cycle.
  - Assert reset_n=0 during WR -> no write, queue empty, INIT restarts.
